// File: rtl/audio_serial_tx.sv
// Parametrised serial audio transmitter: I2S when CH_NUM=2, TDM with one-bclk frame sync otherwise.
// Optional build macro AUDIO_SERIAL_TX_UNDERRUN_HOLD_EN repeats the last good frame on underrun.
module audio_serial_tx #(
    parameter int SAMPLE_W  = 16,
    parameter int SLOT_W    = 16,
    parameter int CH_NUM    = 2,
    parameter int BCLK_HALF = 2,
    parameter int MCLK_HALF = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CH_NUM*SAMPLE_W-1:0] in_data,
    output logic                       frame_start,
    output logic                       underrun,
    output logic                       mclk,
    output logic                       bclk,
    output logic                       lrclk,
    output logic                       sdata
);
    localparam int FRAME_BITS = CH_NUM * SLOT_W;
    localparam int FRAME_W    = CH_NUM * SAMPLE_W;
    localparam int CNT_W      = $clog2(2 * BCLK_HALF);
    localparam int MC_W       = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    localparam int B_W        = $clog2(FRAME_BITS);
    localparam bit TDM_MODE   = (CH_NUM > 2);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * BCLK_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(BCLK_HALF - 1);
    localparam logic [MC_W-1:0]  MC_MAX   = MC_W'(MCLK_HALF - 1);
    localparam logic [B_W-1:0]   B_MAX    = B_W'(FRAME_BITS - 1);
    localparam logic [B_W-1:0]   B_SLOT   = B_W'(SLOT_W);

    logic [MC_W-1:0]       r_mclk_cnt;
    logic                  r_mclk;
    logic [CNT_W-1:0]      r_cnt;
    logic [B_W-1:0]        r_b;
    logic                  r_bclk;
    logic                  r_lrclk;
    logic                  r_sdata;
    logic                  r_delay;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_hold_valid;
    logic [FRAME_W-1:0]    r_hold_data;
    logic                  r_in_ready;
    logic                  r_frame_start;
    logic                  r_underrun;

    logic                  w_fall;
    logic                  w_rise;
    logic                  w_load;
    logic                  w_accept;
    logic                  w_hold_valid_next;
    logic [B_W-1:0]        w_b_next;
    logic [FRAME_W-1:0]    w_underrun_data;
    logic [FRAME_W-1:0]    w_load_data;
    logic [FRAME_BITS-1:0] w_load_stream;

    assign w_fall      = enable && (r_cnt == CNT_MAX);
    assign w_rise      = enable && (r_cnt == CNT_RISE);
    assign w_b_next    = (r_b == B_MAX) ? '0 : r_b + B_W'(1);
    assign w_load      = w_fall && (r_b == B_MAX);
    assign w_accept    = in_valid && r_in_ready;
    assign w_load_data = r_hold_valid ? r_hold_data : w_underrun_data;

    // Stream bit k = s*SLOT_W + p sits at shifter bit FRAME_BITS-1-k; padding bits stay zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_load_stream = '0;
        for (int s = 0; s < CH_NUM; s++) begin
            for (int p = 0; p < SAMPLE_W; p++) begin
                w_load_stream[FRAME_BITS-1-s*SLOT_W-p] = w_load_data[s*SAMPLE_W+SAMPLE_W-1-p];
            end
        end
    end

    always_comb begin
        w_hold_valid_next = r_hold_valid;
        if (w_load && r_hold_valid) begin
            w_hold_valid_next = 1'b0;
        end else if (w_accept) begin
            w_hold_valid_next = 1'b1;
        end
    end

`ifdef AUDIO_SERIAL_TX_UNDERRUN_HOLD_EN
    logic [FRAME_W-1:0] r_last_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_data <= '0;
        end else if (w_load && r_hold_valid) begin
            r_last_data <= r_hold_data;
        end
    end

    assign w_underrun_data = r_last_data;
`else
    assign w_underrun_data = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mclk_cnt <= '0;
            r_mclk     <= 1'b0;
        end else if (r_mclk_cnt == MC_MAX) begin
            r_mclk_cnt <= '0;
            r_mclk     <= ~r_mclk;
        end else begin
            r_mclk_cnt <= r_mclk_cnt + MC_W'(1);
        end
    end

    // Idle parks the phase so the first enabled clk is a falling event with b -> 0.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            r_cnt   <= CNT_MAX;
            r_b     <= B_MAX;
            r_bclk  <= 1'b0;
            r_lrclk <= 1'b0;
            r_sdata <= 1'b0;
            r_delay <= 1'b0;
            r_shift <= '0;
        end else if (!enable) begin
            r_cnt   <= CNT_MAX;
            r_b     <= B_MAX;
            r_bclk  <= 1'b0;
            r_lrclk <= 1'b0;
            r_sdata <= 1'b0;
            r_delay <= 1'b0;
            r_shift <= '0;
        end else begin
            r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CNT_W'(1);
            if (w_rise) begin
                r_bclk <= 1'b1;
            end
            if (w_fall) begin
                r_bclk  <= 1'b0;
                r_b     <= w_b_next;
                r_sdata <= r_delay;
                r_lrclk <= TDM_MODE ? (w_b_next == '0) : (w_b_next >= B_SLOT);
                if (w_load) begin
                    r_delay <= w_load_stream[FRAME_BITS-1];
                    r_shift <= {w_load_stream[FRAME_BITS-2:0], 1'b0};
                end else begin
                    r_delay <= r_shift[FRAME_BITS-1];
                    r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    // NOTE: the holding register is a single frame, so it is reset along with the rest of the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_valid  <= 1'b0;
            r_hold_data   <= '0;
            r_in_ready    <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_hold_valid  <= w_hold_valid_next;
            r_in_ready    <= ~w_hold_valid_next;
            r_frame_start <= w_load;
            r_underrun    <= w_load && !r_hold_valid;
            if (w_accept) begin
                r_hold_data <= in_data;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;
    assign mclk        = r_mclk;
    assign bclk        = r_bclk;
    assign lrclk       = r_lrclk;
    assign sdata       = r_sdata;

endmodule
